// File: rtl/cache_lockstep.sv
// cache_lockstep: N-way lockstep cache SRAM with per-read cross-copy compare,
// sticky first-fail logging, saturating mismatch counter and write-path fault injection.
module cache_lockstep #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_DEPTH = 128,
    parameter int DATA_WIDTH = 64,
    parameter int N_COPIES   = 2,
    parameter int OUT_REGS   = 0,
    parameter int CNT_WIDTH  = 8,
    parameter int SIM_INIT   = 1
) (
    input  logic                           Clk_CI,
    input  logic                           Rst_RBI,
    input  logic                           CSel_SI,
    input  logic                           WrEn_SI,
    input  logic [DATA_WIDTH/8-1:0]        BEn_SI,
    input  logic [DATA_WIDTH-1:0]          WrData_DI,
    input  logic [ADDR_WIDTH-1:0]          Addr_DI,
    input  logic                           InjEn_SI,
    input  logic [$clog2(N_COPIES)-1:0]    InjCopy_SI,
    input  logic [DATA_WIDTH-1:0]          InjMask_DI,
    input  logic                           ErrClr_SI,
    output logic [N_COPIES*DATA_WIDTH-1:0] RdData_DO,
    output logic                           RdValid_SO,
    output logic                           Mismatch_SO,
    output logic                           ErrSticky_SO,
    output logic [ADDR_WIDTH-1:0]          ErrAddr_DO,
    output logic [CNT_WIDTH-1:0]           ErrCnt_DO
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(N_COPIES);

    typedef enum logic [1:0] {IDLE, RD_PEND, VALID} state_t;

    state_t                               st1, st2;
    logic                                 rd, wr, in_range;
    logic [ADDR_WIDTH-1:0]                a1, a2, out_addr;
    logic [N_COPIES-1:0][DATA_WIDTH-1:0]  dout;
    logic [N_COPIES-1:0]                  diff;

    if (DATA_WIDTH % 8 != 0 || N_COPIES < 2 || N_COPIES > 8 || DATA_DEPTH > 2**ADDR_WIDTH ||
        !(SIM_INIT == 0 || SIM_INIT == 1 || SIM_INIT == 3)) begin : g_bad_param
        $error("cache_lockstep: illegal parameter combination");
    end

    assign in_range = int'(Addr_DI) < DATA_DEPTH;
    assign rd       = CSel_SI & ~WrEn_SI;
    assign wr       = CSel_SI & WrEn_SI & in_range;

    for (genvar i = 0; i < N_COPIES; i++) begin : g_copy
        logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
        logic [DATA_WIDTH-1:0] wd, d1, d2;
        // Out-of-range copy indices never match, so they inject nothing.
        assign wd = (InjEn_SI && InjCopy_SI == IW'(i)) ? WrData_DI ^ InjMask_DI : WrData_DI;
        always_ff @(posedge Clk_CI) begin
            for (int b = 0; b < NB; b++)
                if (wr && BEn_SI[b]) mem[Addr_DI][8*b +: 8] <= wd[8*b +: 8];
        end
        always_ff @(posedge Clk_CI) begin
            if (!Rst_RBI) begin
                d1 <= '0;
                d2 <= '0;
            end else begin
                if (rd) d1 <= in_range ? mem[Addr_DI] : '0;
                if (st1 == RD_PEND) d2 <= d1;
            end
        end
        assign dout[i] = OUT_REGS != 0 ? d2 : d1;
        assign diff[i] = dout[i] != dout[0];
    end

    assign RdData_DO   = dout;
    assign RdValid_SO  = (OUT_REGS != 0 ? st2 : st1) == VALID;
    assign Mismatch_SO = RdValid_SO && |diff;
    assign out_addr    = OUT_REGS != 0 ? a2 : a1;

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            st1          <= IDLE;
            st2          <= IDLE;
            a1           <= '0;
            a2           <= '0;
            ErrSticky_SO <= 1'b0;
            ErrAddr_DO   <= '0;
            ErrCnt_DO    <= '0;
        end else begin
            st1 <= rd ? (OUT_REGS != 0 ? RD_PEND : VALID) : IDLE;
            st2 <= st1 == RD_PEND ? VALID : IDLE;
            if (rd) a1 <= Addr_DI;
            if (st1 == RD_PEND) a2 <= a1;
            // A mismatch in the clearing cycle restarts the log with itself.
            if (Mismatch_SO) begin
                ErrSticky_SO <= 1'b1;
                ErrAddr_DO   <= (ErrSticky_SO && !ErrClr_SI) ? ErrAddr_DO : out_addr;
                ErrCnt_DO    <= ErrClr_SI ? CNT_WIDTH'(1) : (&ErrCnt_DO ? ErrCnt_DO : ErrCnt_DO + 1'b1);
            end else if (ErrClr_SI) begin
                ErrSticky_SO <= 1'b0;
                ErrAddr_DO   <= '0;
                ErrCnt_DO    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cache_lockstep.sv
// tb_cache_lockstep: directed checks of three cache_lockstep configurations
// (default, 2-bit counter, 3 copies with output register and reduced depth).
module tb_cache_lockstep;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         csel = 1'b0;
    logic         wen = 1'b0;
    logic [7:0]   ben = '0;
    logic [63:0]  wdata = '0;
    logic [6:0]   addr = '0;
    logic         inj_en = 1'b0;
    logic         inj_copy = 1'b0;
    logic [1:0]   inj_copy3 = '0;
    logic [63:0]  inj_mask = '0;
    logic         err_clr = 1'b0;

    logic [127:0] rd0, rd1;
    logic [191:0] rd2;
    logic         v0, v1, v2, mm0, mm1, mm2, st0, st1, st2;
    logic [6:0]   ea0, ea1, ea2;
    logic [7:0]   cnt0, cnt2;
    logic [1:0]   cnt1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_lockstep u0 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .CSel_SI(csel), .WrEn_SI(wen), .BEn_SI(ben),
        .WrData_DI(wdata), .Addr_DI(addr), .InjEn_SI(inj_en), .InjCopy_SI(inj_copy),
        .InjMask_DI(inj_mask), .ErrClr_SI(err_clr), .RdData_DO(rd0), .RdValid_SO(v0),
        .Mismatch_SO(mm0), .ErrSticky_SO(st0), .ErrAddr_DO(ea0), .ErrCnt_DO(cnt0)
    );

    cache_lockstep #(.CNT_WIDTH(2)) u1 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .CSel_SI(csel), .WrEn_SI(wen), .BEn_SI(ben),
        .WrData_DI(wdata), .Addr_DI(addr), .InjEn_SI(inj_en), .InjCopy_SI(inj_copy),
        .InjMask_DI(inj_mask), .ErrClr_SI(err_clr), .RdData_DO(rd1), .RdValid_SO(v1),
        .Mismatch_SO(mm1), .ErrSticky_SO(st1), .ErrAddr_DO(ea1), .ErrCnt_DO(cnt1)
    );

    cache_lockstep #(.N_COPIES(3), .OUT_REGS(1), .DATA_DEPTH(100)) u2 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .CSel_SI(csel), .WrEn_SI(wen), .BEn_SI(ben),
        .WrData_DI(wdata), .Addr_DI(addr), .InjEn_SI(inj_en), .InjCopy_SI(inj_copy3),
        .InjMask_DI(inj_mask), .ErrClr_SI(err_clr), .RdData_DO(rd2), .RdValid_SO(v2),
        .Mismatch_SO(mm2), .ErrSticky_SO(st2), .ErrAddr_DO(ea2), .ErrCnt_DO(cnt2)
    );

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [63:0] d, input logic [7:0] be,
                      input logic ie, input logic ic, input logic [1:0] ic3, input logic [63:0] m);
        csel = 1'b1; wen = 1'b1; addr = a; wdata = d; ben = be;
        inj_en = ie; inj_copy = ic; inj_copy3 = ic3; inj_mask = m;
        tick();
        csel = 1'b0; wen = 1'b0; inj_en = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        csel = 1'b1; wen = 1'b0; addr = a;
        tick();
        csel = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", v0, 0);
        chk("rst_data", rd0, 0);
        chk("rst_sticky", st0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_addr", ea0, 0);
        rst_n = 1'b1;

        wr(5, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0, 0);
        rd(5);
        chk("rd5_valid", v0, 1);
        chk("rd5_data", rd0, {2{64'h0123456789ABCDEF}});
        chk("rd5_mm", mm0, 0);
        chk("rd5_cnt", cnt0, 0);
        tick();
        chk("idle_valid", v0, 0);
        chk("idle_hold", rd0, {2{64'h0123456789ABCDEF}});

        wr(3, '1, 8'hFF, 0, 0, 0, 0);
        wr(3, 64'h0, 8'h0F, 0, 0, 0, 0);
        rd(3);
        chk("ben_data", rd0, {2{64'hFFFFFFFF00000000}});

        wr(7, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 0, 0, 0, 0);
        wr(7, 64'h0, 8'h00, 1, 1, 0, '1);
        rd(7);
        chk("ben0_data", rd0, {2{64'hAAAAAAAAAAAAAAAA}});
        chk("ben0_mm", mm0, 0);

        wr(9, 64'h0, 8'hFF, 1, 1, 0, 64'h1);
        wr(11, 64'h0, 8'hFF, 1, 0, 0, 64'h100);
        rd(9);
        chk("inj9_data", rd0, {64'h1, 64'h0});
        chk("inj9_mm", mm0, 1);
        chk("inj9_sticky_lat", st0, 0);
        rd(5);
        chk("clean_mm", mm0, 0);
        chk("log_sticky", st0, 1);
        chk("log_addr", ea0, 9);
        chk("log_cnt", cnt0, 1);
        tick();
        chk("log_addr_hold", ea0, 9);
        chk("log_cnt_hold", cnt0, 1);

        for (int i = 0; i < 4; i++) rd(9);
        tick();
        chk("cnt8_five", cnt0, 5);
        chk("cnt2_sat", cnt1, 3);
        chk("cnt2_sticky", st1, 1);

        rd(9);
        chk("sixth_mm", mm1, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clrmm_cnt2", cnt1, 1);
        chk("clrmm_cnt8", cnt0, 1);
        chk("clrmm_sticky", st1, 1);
        chk("clrmm_addr", ea1, 9);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_cnt", cnt0, 0);
        chk("clr_sticky", st0, 0);
        chk("clr_addr", ea0, 0);

        rd(11);
        chk("inj11_data", rd0, {64'h0, 64'h100});
        rd(9);
        tick();
        chk("first_addr", ea0, 11);
        chk("first_cnt", cnt0, 2);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("u2_rst_valid", v2, 0);
        chk("u2_rst_data", rd2, 0);

        wr(20, 64'h1234, 8'hFF, 1, 0, 3, '1);
        rd(20);
        chk("u2_lat1", v2, 0);
        tick();
        chk("u2_lat2", v2, 1);
        chk("u2_injoor_data", rd2, {3{64'h1234}});
        chk("u2_injoor_mm", mm2, 0);

        wr(21, 64'h0, 8'hFF, 0, 0, 0, 0);
        wr(21, 64'h0, 8'h01, 1, 0, 2, 64'hFF00F0);
        rd(21);
        tick();
        chk("u2_inj2_data", rd2, {64'hF0, 64'h0, 64'h0});
        chk("u2_inj2_mm", mm2, 1);
        tick();
        chk("u2_inj2_sticky", st2, 1);
        chk("u2_inj2_addr", ea2, 21);
        chk("u2_inj2_cnt", cnt2, 1);

        wr(120, '1, 8'hFF, 1, 0, 1, '1);
        rd(120);
        tick();
        chk("u2_oor_valid", v2, 1);
        chk("u2_oor_data", rd2, 0);
        chk("u2_oor_mm", mm2, 0);

        wr(1, 64'h1111, 8'hFF, 0, 0, 0, 0);
        wr(2, 64'h2222, 8'hFF, 0, 0, 0, 0);
        wr(3, 64'h3333, 8'hFF, 0, 0, 0, 0);
        rd(1);
        chk("u2_p1_valid", v2, 0);
        rd(2);
        chk("u2_p2_valid", v2, 1);
        chk("u2_p2_data", rd2, {3{64'h1111}});
        rd(3);
        chk("u2_p3_valid", v2, 1);
        chk("u2_p3_data", rd2, {3{64'h2222}});
        tick();
        chk("u2_p4_valid", v2, 1);
        chk("u2_p4_data", rd2, {3{64'h3333}});
        tick();
        chk("u2_p5_valid", v2, 0);
        chk("u2_p5_hold", rd2, {3{64'h3333}});

        rd(1);
        rd(2);
        chk("u2_r2_data", rd2, {3{64'h1111}});
        rd(3);
        chk("u2_r3_data", rd2, {3{64'h2222}});
        rst_n = 1'b0;
        tick();
        chk("u2_mid_valid", v2, 0);
        chk("u2_mid_data", rd2, 0);
        chk("u2_mid_mm", mm2, 0);
        chk("u2_mid_sticky", st2, 0);
        chk("u2_mid_addr", ea2, 0);
        chk("u2_mid_cnt", cnt2, 0);
        rst_n = 1'b1;
        tick();
        chk("u2_post_valid", v2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
